// File: rtl/uart_byte_link.sv
// 8N1 UART transceiver with a byte-level handshake and a one-byte receive hold buffer.
module uart_byte_link #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_BITS     = 16
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_uart_rx,
  output logic       out_uart_tx,
  output logic [7:0] data_rx,
  output logic       rx_done,
  input  logic       rx_trig,
  input  logic [7:0] data_tx,
  input  logic       tx_trig,
  output logic       tx_done,
  output logic       out_tx_busy,
  output logic       out_rx_frame_err,
  output logic       out_rx_overrun
);

  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] HALF_BIT  = CNT_BITS'(CLKS_PER_BIT / 2);
  localparam logic [CNT_BITS-1:0] BIT_LAST  = CNT_BITS'(CLKS_PER_BIT - 1);
  // tx_done occupies the last cycle of the stop bit so a new tx_trig there continues with no gap
  localparam logic [CNT_BITS-1:0] STOP_LAST = CNT_BITS'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t           rx_state_q, rx_state_d;
  logic [CNT_BITS-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_idx_q, rx_idx_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic                frame_err_q, frame_err_d;
  logic                byte_ok;

  logic                armed_q, armed_d;
  logic                pending_q, pending_d;
  logic [7:0]          hold_q, hold_d;
  logic [7:0]          data_rx_q, data_rx_d;
  logic                rx_done_q, rx_done_d;
  logic                overrun_q, overrun_d;

  tx_state_t           tx_state_q, tx_state_d;
  logic [CNT_BITS-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_idx_q, tx_idx_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_line_q, tx_line_d;
  logic                tx_busy_q, tx_busy_d;
  logic                tx_done_q, tx_done_d;

  // Two-stage synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= in_uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX frame FSM: start-bit qualification, mid-bit sampling, stop-bit check
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_ONE;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt_q == HALF_BIT) begin
          if (rx_sync_q) begin
            rx_state_d = R_IDLE;
          end else begin
            rx_cnt_d   = '0;
            rx_idx_d   = '0;
            rx_state_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rx_sync_q) byte_ok     = 1'b1;
          else           frame_err_d = 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Receive delivery: direct when armed, otherwise into the hold buffer
  always_comb begin
    armed_d   = armed_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    data_rx_d = data_rx_q;
    rx_done_d = 1'b0;
    overrun_d = overrun_q;
    if (byte_ok && rx_trig) begin
      // A held byte goes out first; the new byte takes its place, so pending stays set
      rx_done_d = 1'b1;
      armed_d   = 1'b0;
      if (pending_q) begin
        data_rx_d = hold_q;
        hold_d    = rx_shift_q;
      end else begin
        data_rx_d = rx_shift_q;
      end
    end else if (byte_ok) begin
      if (armed_q) begin
        data_rx_d = rx_shift_q;
        rx_done_d = 1'b1;
        armed_d   = 1'b0;
      end else begin
        hold_d    = rx_shift_q;
        pending_d = 1'b1;
        if (pending_q) overrun_d = 1'b1;
      end
    end else if (rx_trig) begin
      if (pending_q) begin
        data_rx_d = hold_q;
        rx_done_d = 1'b1;
        pending_d = 1'b0;
      end else begin
        armed_d = 1'b1;
      end
    end
  end

  // TX frame FSM: start, 8 data bits LSB first, stop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (tx_trig) begin
          tx_data_d  = data_tx;
          tx_idx_d   = '0;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_line_d  = tx_data_q[0];
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_line_d = tx_data_q[tx_idx_q + 3'd1];
          end
        end
      end
      T_STOP: begin
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_busy_d  = 1'b0;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // State registers for both directions
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
      pending_q   <= 1'b0;
      hold_q      <= '0;
      data_rx_q   <= '0;
      rx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      tx_state_q  <= T_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      tx_line_q   <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      hold_q      <= hold_d;
      data_rx_q   <= data_rx_d;
      rx_done_q   <= rx_done_d;
      overrun_q   <= overrun_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      tx_line_q   <= tx_line_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign out_uart_tx      = tx_line_q;
  assign data_rx          = data_rx_q;
  assign rx_done          = rx_done_q;
  assign tx_done          = tx_done_q;
  assign out_tx_busy      = tx_busy_q;
  assign out_rx_frame_err = frame_err_q;
  assign out_rx_overrun   = overrun_q;

endmodule

// File: doc/uart_byte_link.md
Name: uart_byte_link

Overview:
- 8N1 UART transceiver that sits directly upstream of the host-protocol decoder.
- Converts the host serial line into the byte-level handshake the decoder consumes: data_rx, rx_done, rx_trig on the receive side; data_tx, tx_trig, tx_done on the transmit side.
- Drives the host TX line from bytes the decoder produces.
- Has a one-byte hold buffer so a byte that arrives before the decoder re-arms is not lost.

Parameters:
- CLKS_PER_BIT, 434, in_clk cycles per UART bit (50 MHz / 115200); must be >= 8.
- CNT_BITS, 16, width of the bit-timing counter; must satisfy 2^CNT_BITS > CLKS_PER_BIT. Fixed, no $clog2.

Ports:
- in_clk  input  1  single clock.
- in_rst  input  1  synchronous, active-high reset.
- in_uart_rx  input  1  serial line from host, asynchronous, idle high.
- out_uart_tx  output  1  serial line to host, idle high.
- data_rx  output  8  last delivered received byte.
- rx_done  output  1  1-cycle pulse: data_rx holds a new byte.
- rx_trig  input  1  1-cycle pulse: consumer re-arms for the next byte.
- data_tx  input  8  byte to send; sampled on the cycle tx_trig=1.
- tx_trig  input  1  1-cycle pulse: start transmitting data_tx.
- tx_done  output  1  1-cycle pulse: stop bit of the current byte finished.
- out_tx_busy  output  1  transmitter active.
- out_rx_frame_err  output  1  1-cycle pulse: stop bit sampled low, byte discarded.
- out_rx_overrun  output  1  sticky: a pending byte was overwritten.

Behaviour:
Reset (in_rst=1 at a clock edge):
- out_uart_tx=1; rx_done=0; tx_done=0; out_tx_busy=0; out_rx_frame_err=0; out_rx_overrun=0; data_rx=0.
- armed=1, pending=0, RX FSM=R_IDLE, TX FSM=T_IDLE.
- Reset mid-frame aborts both FSMs immediately. out_uart_tx returns high the cycle after reset.

Input synchronisation:
- in_uart_rx passes through a 2-FF synchroniser (reset value 1). All RX decisions use the synchronised value.

RX FSM (R_IDLE, R_START, R_DATA, R_STOP):
- R_IDLE: on the synchronised line falling 1->0, clear the counter and go to R_START.
- R_START: at count CLKS_PER_BIT/2 (integer divide), sample the line.
  - Line=1: glitch, back to R_IDLE, no outputs.
  - Line=0: clear the counter, bit index=0, go to R_DATA.
- R_DATA: every CLKS_PER_BIT cycles, sample and shift into the shift register LSB first. After 8 bits, go to R_STOP.
- R_STOP: sample one CLKS_PER_BIT later (mid stop bit), then return to R_IDLE.
  - Stop bit=0: pulse out_rx_frame_err the next cycle; the byte is dropped.
  - Stop bit=1: the byte is complete; go to delivery.

RX delivery:
- Byte complete while armed=1: data_rx<=byte, rx_done=1 on the next cycle, armed<=0.
- Byte complete while armed=0:
  - pending=0: hold<=byte, pending<=1.
  - pending=1: hold<=byte, out_rx_overrun<=1 (sticky until reset).
- rx_trig=1 with pending=1: data_rx<=hold, rx_done=1 on the next cycle, pending<=0, armed stays 0.
- rx_trig=1 with pending=0: armed<=1.
- rx_trig and byte completion in the same cycle: the completing byte is delivered directly (rx_done next cycle), armed ends 0.
  - If pending was also 1: hold is delivered first, the new byte goes to hold with pending=1, and there is no overrun.
- rx_done is never high on two consecutive cycles.

TX FSM (T_IDLE, T_START, T_DATA, T_STOP):
- T_IDLE: on tx_trig=1, latch data_tx, set out_tx_busy=1 and drive out_uart_tx=0 from the next cycle.
- Each bit lasts exactly CLKS_PER_BIT cycles: start 0, then 8 data bits LSB first, then stop 1.
- At the end of the stop bit: tx_done=1 for one cycle, out_tx_busy=0 in that same cycle, back to T_IDLE.
- tx_trig in the tx_done cycle is accepted: back-to-back bytes with no idle gap.
- tx_trig while busy (other than the tx_done cycle) is ignored.
- One frame = 10*CLKS_PER_BIT cycles from the tx_trig edge to the tx_done pulse.

Width and arithmetic:
- The bit counter is CNT_BITS wide and counts 0..CLKS_PER_BIT-1.
- The bit index is 3 bits; no wrap-around beyond 8 data bits.

Test Plan:
1. CLKS_PER_BIT=16; after reset, drive RX frame 0xA5 with no rx_trig -> rx_done 1-cycle pulse, data_rx=0xA5, armed cleared, out_rx_overrun=0.
2. Drive 0x01 then 0x02 back-to-back without rx_trig; then rx_trig -> rx_done with data_rx=0x02 on the cycle after rx_trig; out_rx_overrun=0. Drive a third byte 0x03, then a fourth 0x04, still without rx_trig -> out_rx_overrun=1.
3. tx_trig with data_tx=0x02 -> out_uart_tx shows 0,0,1,0,0,0,0,0,0,1, each bit 16 cycles; tx_done pulses exactly 160 cycles after tx_trig; out_tx_busy spans that window.
4. tx_trig in the tx_done cycle with 0xFF -> second frame starts with no idle bit. tx_trig mid-frame -> ignored, frame unchanged.
5. RX frame 0x55 with stop bit forced 0 -> out_rx_frame_err pulses, no rx_done. 4-cycle low glitch on idle line -> no rx_done, RX back to R_IDLE.
6. Assert in_rst mid RX frame and mid TX frame -> out_uart_tx=1 next cycle, no rx_done or tx_done; a following clean 0x3C frame is received correctly.
